// File: rtl/obj_ddr_arbiter.sv
// obj_ddr_arbiter: shares one DDR host port between scanout (A) and sprite draw (B).
// A has priority and is never preempted; B yields after a bounded hold while A waits.
//
// Ports:
//   clk, RESET            clock, synchronous active-high reset
//   a_*                   requester A (read-only): acquire, read, addr, burstcnt,
//                         busy, rdata_ready
//   b_*                   requester B: acquire, read, write, addr, burstcnt, wdata,
//                         byteenable, busy, rdata_ready
//   ddr_*                 host port: read, write, addr, burstcnt, wdata, byteenable,
//                         busy (stall in), rdata_ready (in)
//   ddr_rdata             read data in; fanned out directly to both requesters
//
// The grant is registered; the command path is a zero-latency mux of the owner.

module obj_ddr_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int B_MAX_HOLD = 64
) (
  input  logic                clk,
  input  logic                RESET,

  input  logic                a_acquire,
  input  logic                a_read,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [7:0]          a_burstcnt,
  output logic                a_busy,
  output logic                a_rdata_ready,

  input  logic                b_acquire,
  input  logic                b_read,
  input  logic                b_write,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [7:0]          b_burstcnt,
  input  logic [DATA_W-1:0]   b_wdata,
  input  logic [DATA_W/8-1:0] b_byteenable,
  output logic                b_busy,
  output logic                b_rdata_ready,

  output logic                ddr_read,
  output logic                ddr_write,
  output logic [ADDR_W-1:0]   ddr_addr,
  output logic [7:0]          ddr_burstcnt,
  output logic [DATA_W-1:0]   ddr_wdata,
  output logic [DATA_W/8-1:0] ddr_byteenable,
  input  logic                ddr_busy,
  input  logic [DATA_W-1:0]   ddr_rdata,
  input  logic                ddr_rdata_ready
);

  localparam int HOLD_W = $clog2(B_MAX_HOLD + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWN_A = 2'd1;
  localparam logic [1:0] S_OWN_B = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              owner_b_q, owner_b_d;
  logic [8:0]        pend_q, pend_d;
  logic [7:0]        wbeats_q, wbeats_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic own_a;
  logic own_b;
  logic hold_max;
  logic b_yield;
  logic b_gate;
  logic rd_acc;
  logic wr_acc;
  logic active;
  logic [8:0] bc_eff;

  // read data is not consumed by the arbiter; requesters take it directly
  logic unused_rdata;
  assign unused_rdata = ^ddr_rdata;

  assign own_a    = (state_q == S_OWN_A);
  assign own_b    = (state_q == S_OWN_B);
  assign hold_max = (hold_q == HOLD_W'(B_MAX_HOLD));

  // B yields only between write bursts
  assign b_yield = own_b && hold_max && (wbeats_q == 8'd0);
  assign b_gate  = own_b && !b_yield;

  always_comb begin
    ddr_read       = 1'b0;
    ddr_write      = 1'b0;
    ddr_addr       = '0;
    ddr_burstcnt   = '0;
    ddr_wdata      = '0;
    ddr_byteenable = '1;
    a_busy         = 1'b1;
    b_busy         = 1'b1;
    if (own_a) begin
      ddr_read     = a_read;
      ddr_addr     = a_addr;
      ddr_burstcnt = a_burstcnt;
      a_busy       = ddr_busy;
    end
    if (b_gate) begin
      ddr_read       = b_read;
      ddr_write      = b_write;
      ddr_addr       = b_addr;
      ddr_burstcnt   = b_burstcnt;
      ddr_wdata      = b_wdata;
      ddr_byteenable = b_byteenable;
      b_busy         = ddr_busy;
    end
  end

  assign rd_acc = ddr_read  && !ddr_busy;
  assign wr_acc = ddr_write && !ddr_busy;

  // a zero burst length is treated as a single beat
  assign bc_eff = (ddr_burstcnt == 8'd0) ? 9'd1 : {1'b0, ddr_burstcnt};

  // the owner is remembered through DRAIN so returning beats still route
  assign active        = (state_q != S_IDLE);
  assign a_rdata_ready = ddr_rdata_ready && active && !owner_b_q;
  assign b_rdata_ready = ddr_rdata_ready && active &&  owner_b_q;

  always_comb begin
    pend_d = pend_q;
    if (rd_acc) begin
      pend_d = pend_d + bc_eff;
    end
    // stray beats with nothing outstanding must not wrap the counter
    if (ddr_rdata_ready && (pend_q != 9'd0)) begin
      pend_d = pend_d - 9'd1;
    end
  end

  always_comb begin
    wbeats_d = wbeats_q;
    if (wr_acc) begin
      if (wbeats_q == 8'd0) begin
        wbeats_d = (ddr_burstcnt == 8'd0) ? 8'd0 : ddr_burstcnt - 8'd1;
      end else begin
        wbeats_d = wbeats_q - 8'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_b_d = owner_b_q;
    hold_d    = hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (a_acquire) begin
          state_d   = S_OWN_A;
          owner_b_d = 1'b0;
        end else if (b_acquire) begin
          state_d   = S_OWN_B;
          owner_b_d = 1'b1;
        end
      end
      S_OWN_A: begin
        if (!a_acquire) begin
          state_d = S_DRAIN;
        end
      end
      S_OWN_B: begin
        if (!b_acquire || b_yield) begin
          state_d = S_DRAIN;
        end else if (a_acquire && !hold_max) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_DRAIN: begin
        if ((pend_d == 9'd0) && (wbeats_d == 8'd0)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (state_d != S_OWN_B) begin
      hold_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      owner_b_q <= 1'b0;
      pend_q    <= '0;
      wbeats_q  <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_b_q <= owner_b_d;
      pend_q    <= pend_d;
      wbeats_q  <= wbeats_d;
      hold_q    <= hold_d;
    end
  end

endmodule

// File: tb/tb_obj_ddr_arbiter.sv
// tb_obj_ddr_arbiter: directed scenarios for obj_ddr_arbiter.
// B_MAX_HOLD is set to 16 so the forced-yield timing is short.

module tb_obj_ddr_arbiter;

  logic        clk = 1'b0;
  logic        RESET;
  logic        a_acquire, a_read;
  logic [31:0] a_addr;
  logic [7:0]  a_burstcnt;
  logic        a_busy, a_rdata_ready;
  logic        b_acquire, b_read, b_write;
  logic [31:0] b_addr;
  logic [7:0]  b_burstcnt;
  logic [63:0] b_wdata;
  logic [7:0]  b_byteenable;
  logic        b_busy, b_rdata_ready;
  logic        ddr_read, ddr_write;
  logic [31:0] ddr_addr;
  logic [7:0]  ddr_burstcnt;
  logic [63:0] ddr_wdata;
  logic [7:0]  ddr_byteenable;
  logic        ddr_busy;
  logic [63:0] ddr_rdata;
  logic        ddr_rdata_ready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  obj_ddr_arbiter #(
    .ADDR_W(32), .DATA_W(64), .B_MAX_HOLD(16)
  ) dut (
    .clk(clk), .RESET(RESET),
    .a_acquire(a_acquire), .a_read(a_read), .a_addr(a_addr),
    .a_burstcnt(a_burstcnt), .a_busy(a_busy),
    .a_rdata_ready(a_rdata_ready),
    .b_acquire(b_acquire), .b_read(b_read), .b_write(b_write),
    .b_addr(b_addr), .b_burstcnt(b_burstcnt), .b_wdata(b_wdata),
    .b_byteenable(b_byteenable), .b_busy(b_busy),
    .b_rdata_ready(b_rdata_ready),
    .ddr_read(ddr_read), .ddr_write(ddr_write), .ddr_addr(ddr_addr),
    .ddr_burstcnt(ddr_burstcnt), .ddr_wdata(ddr_wdata),
    .ddr_byteenable(ddr_byteenable), .ddr_busy(ddr_busy),
    .ddr_rdata(ddr_rdata), .ddr_rdata_ready(ddr_rdata_ready)
  );

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    a_acquire = 0; a_read = 0; a_addr = 0; a_burstcnt = 0;
    b_acquire = 0; b_read = 0; b_write = 0; b_addr = 0;
    b_burstcnt = 0; b_wdata = 0; b_byteenable = 0;
    ddr_busy = 0; ddr_rdata = 0; ddr_rdata_ready = 0;
  endtask

  task automatic go_idle();
    clr_inputs();
    repeat (4) nxt();
  endtask

  task automatic test_reset();
    RESET = 1;
    clr_inputs();
    nxt();
    nxt();
    ddr_rdata_ready = 1;
    #1;
    checks++;
    if (ddr_read !== 1'b0 || ddr_write !== 1'b0) begin
      failures++;
      $display("FAIL rst_cmd rd=%b wr=%b exp 0 0", ddr_read, ddr_write);
    end
    checks++;
    if (a_busy !== 1'b1 || b_busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_busy a=%b b=%b exp 1 1", a_busy, b_busy);
    end
    checks++;
    if (a_rdata_ready !== 1'b0 || b_rdata_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_rdy a=%b b=%b exp 0 0", a_rdata_ready, b_rdata_ready);
    end
    ddr_rdata_ready = 0;
    nxt();
    RESET = 0;
    nxt();
  endtask

  task automatic test_a_read();
    int cnt = 0;
    int stray = 0;
    nxt();
    a_acquire = 1; a_read = 1; a_addr = 32'h400; a_burstcnt = 8'd80;
    #1;
    checks++;
    if (a_busy !== 1'b1 || ddr_read !== 1'b0) begin
      failures++;
      $display("FAIL a_idle busy=%b rd=%b exp 1 0", a_busy, ddr_read);
    end
    nxt();
    #1;
    checks++;
    if (a_busy !== 1'b0 || ddr_read !== 1'b1 || b_busy !== 1'b1) begin
      failures++;
      $display("FAIL a_grant abusy=%b rd=%b bbusy=%b exp 0 1 1",
               a_busy, ddr_read, b_busy);
    end
    checks++;
    if (ddr_addr !== 32'h400 || ddr_burstcnt !== 8'd80) begin
      failures++;
      $display("FAIL a_cmd addr=%h bc=%0d exp 400 80", ddr_addr, ddr_burstcnt);
    end
    nxt();
    a_read = 0; a_acquire = 0;
    for (int i = 0; i < 80; i++) begin
      ddr_rdata_ready = 1;
      ddr_rdata = 64'(i);
      if (i == 79) b_acquire = 1;
      #1;
      if (a_rdata_ready === 1'b1) cnt++;
      if (b_rdata_ready !== 1'b0 || ddr_read !== 1'b0) stray++;
      nxt();
    end
    ddr_rdata_ready = 0;
    #1;
    checks++;
    if (cnt != 80 || stray != 0) begin
      failures++;
      $display("FAIL a_beats got=%0d stray=%0d exp 80 0", cnt, stray);
    end
    checks++;
    if (b_busy !== 1'b1) begin
      failures++;
      $display("FAIL a_idle_after b_busy=%b exp 1", b_busy);
    end
    nxt();
    #1;
    checks++;
    if (b_busy !== 1'b0) begin
      failures++;
      $display("FAIL a_then_b b_busy=%b exp 0", b_busy);
    end
    go_idle();
  endtask

  task automatic test_both();
    int n = 0;
    nxt();
    a_acquire = 1; b_acquire = 1; a_read = 1;
    a_addr = 32'h800; a_burstcnt = 8'd2;
    nxt();
    #1;
    checks++;
    if (a_busy !== 1'b0 || b_busy !== 1'b1 || ddr_addr !== 32'h800) begin
      failures++;
      $display("FAIL both_prio a=%b b=%b addr=%h exp 0 1 800",
               a_busy, b_busy, ddr_addr);
    end
    nxt();
    a_read = 0; a_acquire = 0; ddr_rdata_ready = 1;
    #1;
    checks++;
    if (b_busy !== 1'b1 || a_rdata_ready !== 1'b1) begin
      failures++;
      $display("FAIL both_beat1 b=%b ardy=%b exp 1 1", b_busy, a_rdata_ready);
    end
    nxt();
    #1;
    checks++;
    if (b_busy !== 1'b1 || b_rdata_ready !== 1'b0) begin
      failures++;
      $display("FAIL both_drain b=%b brdy=%b exp 1 0", b_busy, b_rdata_ready);
    end
    nxt();
    ddr_rdata_ready = 0;
    #1;
    while (b_busy !== 1'b0 && n < 4) begin
      nxt();
      #1;
      n++;
    end
    checks++;
    if (b_busy !== 1'b0 || n > 2) begin
      failures++;
      $display("FAIL both_b_late b=%b cycles=%0d exp 0 <=2", b_busy, n);
    end
    go_idle();
  endtask

  task automatic test_b_write();
    nxt();
    b_acquire = 1;
    nxt();
    b_write = 1; b_addr = 32'h1000; b_burstcnt = 8'd4;
    b_wdata = 64'hA0; b_byteenable = 8'h0F; a_acquire = 1;
    #1;
    checks++;
    if (ddr_write !== 1'b1 || ddr_addr !== 32'h1000 ||
        ddr_burstcnt !== 8'd4 || b_busy !== 1'b0) begin
      failures++;
      $display("FAIL bw_beat1 wr=%b addr=%h bc=%0d bb=%b exp 1 1000 4 0",
               ddr_write, ddr_addr, ddr_burstcnt, b_busy);
    end
    checks++;
    if (ddr_wdata !== 64'hA0 || ddr_byteenable !== 8'h0F) begin
      failures++;
      $display("FAIL bw_data wd=%h be=%h exp a0 0f", ddr_wdata, ddr_byteenable);
    end
    nxt();
    b_wdata = 64'hA1; ddr_busy = 1;
    #1;
    checks++;
    if (b_busy !== 1'b1 || a_busy !== 1'b1 || ddr_write !== 1'b1) begin
      failures++;
      $display("FAIL bw_stall bb=%b ab=%b wr=%b exp 1 1 1",
               b_busy, a_busy, ddr_write);
    end
    nxt();
    ddr_busy = 0;
    #1;
    checks++;
    if (b_busy !== 1'b0 || ddr_wdata !== 64'hA1) begin
      failures++;
      $display("FAIL bw_beat2 bb=%b wd=%h exp 0 a1", b_busy, ddr_wdata);
    end
    nxt();
    b_wdata = 64'hA2;
    nxt();
    b_wdata = 64'hA3;
    #1;
    checks++;
    if (b_busy !== 1'b0 || a_busy !== 1'b1 || ddr_wdata !== 64'hA3) begin
      failures++;
      $display("FAIL bw_beat4 bb=%b ab=%b wd=%h exp 0 1 a3",
               b_busy, a_busy, ddr_wdata);
    end
    nxt();
    b_write = 0; b_acquire = 0;
    nxt();
    nxt();
    #1;
    checks++;
    if (a_busy !== 1'b1) begin
      failures++;
      $display("FAIL bw_a_early a_busy=%b exp 1", a_busy);
    end
    nxt();
    #1;
    checks++;
    if (a_busy !== 1'b0) begin
      failures++;
      $display("FAIL bw_a_grant a_busy=%b exp 0", a_busy);
    end
    go_idle();
  endtask

  task automatic test_hold();
    int bad = 0;
    nxt();
    b_acquire = 1;
    nxt();
    b_write = 1; b_burstcnt = 8'd1; b_addr = 32'h2000;
    b_wdata = 64'h55; b_byteenable = 8'h3C; a_acquire = 1;
    #1;
    checks++;
    if (b_busy !== 1'b0 || ddr_write !== 1'b1) begin
      failures++;
      $display("FAIL hold_t0 bb=%b wr=%b exp 0 1", b_busy, ddr_write);
    end
    for (int k = 1; k < 16; k++) begin
      nxt();
      #1;
      if (b_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_early busy_cycles=%0d exp 0", bad);
    end
    nxt();
    #1;
    checks++;
    if (b_busy !== 1'b1 || ddr_write !== 1'b0 || a_busy !== 1'b1) begin
      failures++;
      $display("FAIL hold_t16 bb=%b wr=%b ab=%b exp 1 0 1",
               b_busy, ddr_write, a_busy);
    end
    nxt();
    nxt();
    #1;
    checks++;
    if (a_busy !== 1'b1) begin
      failures++;
      $display("FAIL hold_t18 ab=%b exp 1", a_busy);
    end
    nxt();
    #1;
    checks++;
    if (a_busy !== 1'b0 || b_busy !== 1'b1 || ddr_write !== 1'b0) begin
      failures++;
      $display("FAIL hold_t19 ab=%b bb=%b wr=%b exp 0 1 0",
               a_busy, b_busy, ddr_write);
    end
    checks++;
    if (ddr_wdata !== 64'h0 || ddr_byteenable !== 8'hFF) begin
      failures++;
      $display("FAIL hold_a_mux wd=%h be=%h exp 0 ff", ddr_wdata, ddr_byteenable);
    end
    a_acquire = 0;
    nxt();
    nxt();
    nxt();
    #1;
    checks++;
    if (b_busy !== 1'b0 || ddr_write !== 1'b1) begin
      failures++;
      $display("FAIL hold_regrant bb=%b wr=%b exp 0 1", b_busy, ddr_write);
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    nxt();
    a_acquire = 1; a_read = 1; a_addr = 32'h40; a_burstcnt = 8'd40;
    nxt();
    #1;
    checks++;
    if (ddr_read !== 1'b1) begin
      failures++;
      $display("FAIL rm_issue rd=%b exp 1", ddr_read);
    end
    nxt();
    a_read = 0; RESET = 1;
    nxt();
    RESET = 0; a_acquire = 0; ddr_rdata_ready = 1;
    #1;
    checks++;
    if (a_busy !== 1'b1 || b_busy !== 1'b1 || ddr_read !== 1'b0 ||
        a_rdata_ready !== 1'b0) begin
      failures++;
      $display("FAIL rm_after ab=%b bb=%b rd=%b ardy=%b exp 1 1 0 0",
               a_busy, b_busy, ddr_read, a_rdata_ready);
    end
    nxt();
    #1;
    checks++;
    if (a_rdata_ready !== 1'b0) begin
      failures++;
      $display("FAIL rm_late ardy=%b exp 0", a_rdata_ready);
    end
    nxt();
    ddr_rdata_ready = 0; b_acquire = 1;
    nxt();
    #1;
    checks++;
    if (b_busy !== 1'b0) begin
      failures++;
      $display("FAIL rm_b_grant bb=%b exp 0", b_busy);
    end
    b_acquire = 0;
    nxt();
    a_acquire = 1;
    nxt();
    nxt();
    #1;
    checks++;
    if (a_busy !== 1'b0) begin
      failures++;
      $display("FAIL rm_pend_clr ab=%b exp 0", a_busy);
    end
    go_idle();
  endtask

  task automatic test_same_cycle();
    nxt();
    a_acquire = 1; a_read = 1; a_burstcnt = 8'd1; a_addr = 32'h10;
    nxt();
    #1;
    checks++;
    if (ddr_read !== 1'b1 || ddr_burstcnt !== 8'd1) begin
      failures++;
      $display("FAIL sc_r1 rd=%b bc=%0d exp 1 1", ddr_read, ddr_burstcnt);
    end
    nxt();
    a_burstcnt = 8'd2; a_addr = 32'h18; ddr_rdata_ready = 1;
    #1;
    checks++;
    if (a_rdata_ready !== 1'b1 || ddr_burstcnt !== 8'd2) begin
      failures++;
      $display("FAIL sc_r2 ardy=%b bc=%0d exp 1 2", a_rdata_ready, ddr_burstcnt);
    end
    nxt();
    a_read = 0; a_acquire = 0;
    nxt();
    ddr_rdata_ready = 0; b_acquire = 1;
    #1;
    checks++;
    if (b_busy !== 1'b1) begin
      failures++;
      $display("FAIL sc_r4 bb=%b exp 1", b_busy);
    end
    nxt();
    ddr_rdata_ready = 1;
    #1;
    checks++;
    if (a_rdata_ready !== 1'b1) begin
      failures++;
      $display("FAIL sc_r5 ardy=%b exp 1", a_rdata_ready);
    end
    nxt();
    ddr_rdata_ready = 0;
    #1;
    checks++;
    if (b_busy !== 1'b1) begin
      failures++;
      $display("FAIL sc_r6 bb=%b exp 1", b_busy);
    end
    nxt();
    #1;
    checks++;
    if (b_busy !== 1'b0) begin
      failures++;
      $display("FAIL sc_r7 bb=%b exp 0", b_busy);
    end
    go_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1;
    clr_inputs();
    test_reset();
    test_a_read();
    test_both();
    test_b_write();
    test_hold();
    test_reset_mid();
    test_same_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
